// File: rtl/instr_pkg.sv
// -----------------------------------------------------------------------------
// instr_pkg
// Definitions shared by the instruction fetch unit and the control unit:
// instruction/PC widths, opcode constants, the fetch FSM state type and a
// helper that extracts the opcode field of an instruction word.
// Instruction format: iiiidddddd (4-bit opcode, 6-bit operand field).
// -----------------------------------------------------------------------------
package instr_pkg;

    localparam int PC_W      = 8;
    localparam int INSTR_W   = 10;
    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = INSTR_W - OPCODE_W;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_ADD   = 4'b0000;
    localparam opcode_t OP_SUB   = 4'b0001;
    localparam opcode_t OP_ADDI  = 4'b0010;
    localparam opcode_t OP_AND   = 4'b0011;
    localparam opcode_t OP_OR    = 4'b0100;
    localparam opcode_t OP_XOR   = 4'b0101;
    localparam opcode_t OP_SHL   = 4'b0110;
    localparam opcode_t OP_SHR   = 4'b0111;
    localparam opcode_t OP_LOAD  = 4'b1000;
    localparam opcode_t OP_JMP   = 4'b1001;
    localparam opcode_t OP_BEQ   = 4'b1010;
    localparam opcode_t OP_BNE   = 4'b1011;
    localparam opcode_t OP_STORE = 4'b1100;
    localparam opcode_t OP_HLT   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    function automatic opcode_t opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: OPCODE_W];
    endfunction

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter with next-PC selection. When 'advance' is high the PC moves
// to 'target' (jump) or to PC+1, wrapping modulo 2^PC_W; otherwise pc_next
// simply reflects the current PC.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (PC clears to 0)
//   advance     update the PC this cycle
//   jump        select 'target' instead of the increment (only with advance)
//   target      jump destination
//   pc          current program counter
//   pc_next     value the PC takes at the next edge (combinational)
// -----------------------------------------------------------------------------
module pc_reg #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            jump,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next
);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pc_next = pc;
        if (advance) begin
            pc_next = jump ? target : pc + PC_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (advance) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction-side initiator: holds the PC, reads the synchronous program
// memory (one-cycle read latency) and presents each instruction word to the
// control unit over a valid/ready handshake. A jump request (load_PC /
// pc_value) is taken only in the cycle the instruction is accepted. Accepting
// an HLT word stops fetching until reset.
//
// Optional build macro INSTR_FETCH_SINGLE_STEP_EN adds a 'step' input: leaving
// IDLE then needs run && step, and every accepted instruction returns to IDLE.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   run          level enable for fetching
//   step         (single-step build only) one-cycle advance pulse
//   imem_addr    program memory address (pc_next while strobing, else held)
//   imem_rd_en   read strobe; data arrives on imem_rdata one cycle later
//   imem_rdata   program memory read data
//   instr        instruction presented to the control unit
//   instr_valid  instr is valid
//   instr_ready  control unit accepts instr this cycle
//   load_PC      jump request, sampled in the accept cycle
//   pc_value     jump target
//   pc           address of the instruction held in instr
//   halt         HLT retired; fetching stopped
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
`ifdef INSTR_FETCH_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               load_PC,
    input  logic [PC_W-1:0]    pc_value,
    output logic [PC_W-1:0]    pc,
    output logic               halt
);

    import instr_pkg::*;

    fetch_state_t    state;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] last_addr;
    logic            accept;
    logic            hlt_word;
    logic            start;
    logic            chain;

    assign accept   = (state == VALID) && instr_ready;
    assign hlt_word = (opcode_of(instr) == OP_HLT);

`ifdef INSTR_FETCH_SINGLE_STEP_EN
    assign start = run && step;
    assign chain = 1'b0;
`else
    assign start = run;
    assign chain = run;
`endif

    // An HLT word never jumps: load_PC is ignored when it is accepted.
    pc_reg #(.PC_W(PC_W)) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (accept),
        .jump    (load_PC && !hlt_word),
        .target  (pc_value),
        .pc      (pc),
        .pc_next (pc_next)
    );

    // The strobe is combinational so the next read leaves in the accept cycle
    // itself. Gating with rst_n keeps it low while reset is held even though
    // IDLE with run=1 would otherwise request a read.
    assign imem_rd_en = rst_n && (((state == IDLE) && start) ||
                                  (accept && !hlt_word && chain));
    assign imem_addr  = imem_rd_en ? pc_next : last_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            halt        <= 1'b0;
            last_addr   <= '0;
        end else begin
            if (imem_rd_en) begin
                last_addr <= pc_next;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    instr       <= imem_rdata;
                    instr_valid <= 1'b1;
                    state       <= VALID;
                end
                VALID: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (hlt_word) begin
                            state <= HALT;
                            halt  <= 1'b1;
                        end else if (chain) begin
                            state <= WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with a behavioural synchronous program
// memory. Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    import instr_pkg::*;

    localparam int PW = 8;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          instr_ready = 1'b0;
    logic          load_PC = 1'b0;
    logic [PW-1:0] pc_value = '0;
    logic [PW-1:0] imem_addr;
    logic          imem_rd_en;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [PW-1:0] pc;
    logic          halt;

    logic [IW-1:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous program memory: one-cycle read latency.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    instr_fetch_unit #(.PC_W(PW), .INSTR_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
`ifdef INSTR_FETCH_SINGLE_STEP_EN
        .step        (step),
`endif
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .load_PC     (load_PC),
        .pc_value    (pc_value),
        .pc          (pc),
        .halt        (halt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},    32'(pc),          32'h0);
        check({tag, "_instr"}, 32'(instr),       32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_rd_en"}, 32'(imem_rd_en),  32'h0);
        check({tag, "_addr"},  32'(imem_addr),   32'h0);
        check({tag, "_halt"},  32'(halt),        32'h0);
    endtask

    // Reset pulse; returns at a falling edge with rst_n released and run=0.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0; load_PC = 1'b0; step = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // From the cycle after a read strobe: WAIT cycle, then VALID cycle.
    // Returns 1 ns after the falling edge of the VALID cycle.
    task automatic fetch_word(input logic [PW-1:0] exp_pc);
        @(negedge clk);
        load_PC = 1'b0; step = 1'b0;
        #1;
        check("wait_valid", 32'(instr_valid), 32'h0);
        check("wait_pc",    32'(pc),          32'(exp_pc));
        check("wait_rd_en", 32'(imem_rd_en),  32'h0);
        @(negedge clk);
        #1;
        check("valid",       32'(instr_valid), 32'h1);
        check("valid_pc",    32'(pc),          32'(exp_pc));
        check("valid_instr", 32'(instr),       32'(mem[exp_pc]));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {OP_ADD, i[5:0]};

`ifdef INSTR_FETCH_SINGLE_STEP_EN
        do_reset();
        run = 1'b1; instr_ready = 1'b1;
        #1;
        check("step_idle_rd_en", 32'(imem_rd_en), 32'h0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); #1;
            check("step_nostep_rd_en", 32'(imem_rd_en),  32'h0);
            check("step_nostep_valid", 32'(instr_valid), 32'h0);
        end
        @(negedge clk); step = 1'b1; #1;
        check("step1_rd_en", 32'(imem_rd_en), 32'h1);
        check("step1_addr",  32'(imem_addr),  32'h0);
        fetch_word(8'h00);
        check("step1_no_chain", 32'(imem_rd_en), 32'h0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk); #1;
            check("step_gap_valid", 32'(instr_valid), 32'h0);
            check("step_gap_rd_en", 32'(imem_rd_en),  32'h0);
            check("step_gap_pc",    32'(pc),          32'h1);
        end
        @(negedge clk); step = 1'b1; #1;
        check("step2_rd_en", 32'(imem_rd_en), 32'h1);
        check("step2_addr",  32'(imem_addr),  32'h1);
        fetch_word(8'h01);
        check("step2_no_chain", 32'(imem_rd_en), 32'h0);
`else
        // ---- reset values, then idle with run=0 ----
        #1;
        check_reset_values("rst");
        @(negedge clk); rst_n = 1'b1; #1;
        check("idle_run0_rd_en", 32'(imem_rd_en), 32'h0);
        @(negedge clk); #1;
        check("idle_run0_rd_en2", 32'(imem_rd_en),  32'h0);
        check("idle_run0_valid",  32'(instr_valid), 32'h0);

        // ---- ADD, SUB, ADDI, HLT streamed with ready high ----
        mem[0] = {OP_ADD,  6'h05};
        mem[1] = {OP_SUB,  6'h0A};
        mem[2] = {OP_ADDI, 6'h0F};
        mem[3] = {OP_HLT,  6'h00};
        @(negedge clk); run = 1'b1; instr_ready = 1'b1; #1;
        check("start_rd_en", 32'(imem_rd_en), 32'h1);
        check("start_addr",  32'(imem_addr),  32'h0);
        for (int k = 0; k < 4; k++) begin
            fetch_word(PW'(k));
            if (k < 3) begin
                check("chain_rd_en", 32'(imem_rd_en), 32'h1);
                check("chain_addr",  32'(imem_addr),  32'(k + 1));
            end else begin
                check("hlt_accept_rd_en", 32'(imem_rd_en), 32'h0);
            end
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); #1;
            check("halt",       32'(halt),        32'h1);
            check("halt_valid", 32'(instr_valid), 32'h0);
            check("halt_rd_en", 32'(imem_rd_en),  32'h0);
        end

        // ---- stall at pc=1 for 5 cycles, load_PC pulse ignored ----
        do_reset();
        run = 1'b1; instr_ready = 1'b1;
        fetch_word(8'h00);
        fetch_word(8'h01);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            instr_ready = 1'b0;
            load_PC = (j == 2);
            pc_value = 8'h20;
            #1;
            check("stall_valid", 32'(instr_valid), 32'h1);
            check("stall_pc",    32'(pc),          32'h1);
            check("stall_instr", 32'(instr),       32'(mem[1]));
            check("stall_rd_en", 32'(imem_rd_en),  32'h0);
        end
        @(negedge clk); instr_ready = 1'b1; load_PC = 1'b0; #1;
        check("unstall_rd_en", 32'(imem_rd_en), 32'h1);
        check("unstall_addr",  32'(imem_addr),  32'h2);
        fetch_word(8'h02);

        // ---- JMP at pc=4 to 0x20, then to 0xFF, then wrap ----
        do_reset();
        mem[3]    = {OP_ADD, 6'h03};
        mem[4]    = {OP_JMP, 6'h20};
        mem[8'h20] = {OP_JMP, 6'h3F};
        mem[8'hFF] = {OP_SUB, 6'h11};
        run = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) fetch_word(PW'(k));
        load_PC = 1'b1; pc_value = 8'h20; #1;
        check("jmp_rd_en", 32'(imem_rd_en), 32'h1);
        check("jmp_addr",  32'(imem_addr),  32'h20);
        fetch_word(8'h20);
        load_PC = 1'b1; pc_value = 8'hFF; #1;
        check("jmp_ff_addr", 32'(imem_addr), 32'hFF);
        fetch_word(8'hFF);
        check("wrap_rd_en", 32'(imem_rd_en), 32'h1);
        check("wrap_addr",  32'(imem_addr),  32'h00);
        fetch_word(8'h00);

        // ---- reset during WAIT at pc=7 ----
        do_reset();
        mem[4] = {OP_ADD, 6'h04};
        run = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 7; k++) fetch_word(PW'(k));
        @(negedge clk); #1;
        check("pre_rst_pc",    32'(pc),          32'h7);
        check("pre_rst_valid", 32'(instr_valid), 32'h0);
        rst_n = 1'b0; #1;
        check_reset_values("midrst");
        @(negedge clk); rst_n = 1'b1; #1;
        check("post_rst_rd_en", 32'(imem_rd_en), 32'h1);
        check("post_rst_addr",  32'(imem_addr),  32'h0);
        fetch_word(8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
